// File: rtl/step_ctrl_if.sv
// Bundle of the step/run inputs and the enable/status outputs of step_ctrl.
// The master is the board side and drives the raw inputs; the slave is step_ctrl.
interface step_ctrl_if #(
    parameter int CNT_W = 16
);
    logic             step;
    logic             run;
    logic             cpu_en;
    logic             step_db;
    logic [CNT_W-1:0] cycle_count;

    modport master (output step, run, input cpu_en, step_db, cycle_count);
    modport slave  (input step, run, output cpu_en, step_db, cycle_count);
endinterface

// File: rtl/step_ctrl.sv
// Single-step / free-run controller: synchronizes and debounces the pushbutton
// and run switch, and produces the core clock-enable plus an enabled-cycle count.
module step_ctrl #(
    parameter int DB_CYCLES = 50000,
    parameter int CNT_W     = 16
) (
    input  logic        clk,
    input  logic        rst,
    step_ctrl_if.slave  bus
);
    localparam int DBW = (DB_CYCLES > 2) ? $clog2(DB_CYCLES) : 1;
    localparam logic [DBW-1:0] DB_MAX = DBW'(DB_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_FIRE = 2'd1,
        S_HOLD = 2'd2,
        S_RUN  = 2'd3
    } state_t;

    logic           step_m, step_q;
    logic           run_m, run_s;
    logic           step_s;
    logic           stable;
    logic [DBW-1:0] db_cnt;
    state_t         state, state_nx;
    logic           cpu_en;
    logic [CNT_W-1:0] cycle_count;

    // Raw inputs are sampled on the first flop only; the step path keeps its
    // raw active-low polarity until after the second flop.
    always_ff @(posedge clk) begin
        if (rst) begin
            step_m <= 1'b1;
            step_q <= 1'b1;
            run_m  <= 1'b0;
            run_s  <= 1'b0;
        end else begin
            step_m <= bus.step;
            step_q <= step_m;
            run_m  <= bus.run;
            run_s  <= run_m;
        end
    end

    assign step_s = ~step_q;

    // Any sample matching the stable level restarts the window.
    always_ff @(posedge clk) begin
        if (rst) begin
            stable <= 1'b0;
            db_cnt <= '0;
        end else if (step_s == stable) begin
            db_cnt <= '0;
        end else if (db_cnt == DB_MAX) begin
            stable <= step_s;
            db_cnt <= '0;
        end else begin
            db_cnt <= db_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        if (run_s) begin
            state_nx = S_RUN;
        end else begin
            case (state)
                S_IDLE:  if (stable) state_nx = S_FIRE;
                S_FIRE:  state_nx = S_HOLD;
                S_HOLD:  if (!stable) state_nx = S_IDLE;
                // A button still held when leaving run mode must not fire.
                S_RUN:   state_nx = stable ? S_HOLD : S_IDLE;
                default: state_nx = S_IDLE;
            endcase
        end
    end

    always_comb begin
        cpu_en = 1'b0;
        case (state)
            S_FIRE:  cpu_en = 1'b1;
            S_RUN:   cpu_en = 1'b1;
            default: cpu_en = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst)         cycle_count <= '0;
        else if (cpu_en) cycle_count <= cycle_count + 1'b1;
    end

    assign bus.cpu_en      = cpu_en;
    assign bus.step_db     = stable;
    assign bus.cycle_count = cycle_count;
endmodule

// File: tb/tb_step_ctrl.sv
// Bench for step_ctrl: two instances (16-bit and 4-bit counters) share stimulus
// and are compared every cycle against an event-level model of the controller.
module tb_step_ctrl;
    localparam int DB = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    step_ctrl_if #(.CNT_W(16)) bus16 ();
    step_ctrl_if #(.CNT_W(4))  bus4  ();

    step_ctrl #(.DB_CYCLES(DB), .CNT_W(16)) dut16 (.clk(clk), .rst(rst), .bus(bus16));
    step_ctrl #(.DB_CYCLES(DB), .CNT_W(4))  dut4  (.clk(clk), .rst(rst), .bus(bus4));

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, got, exp);
        end
    endtask

    // Model: inputs delayed two samples, button accepted once the last DB
    // samples all disagree with the accepted level, and enable decided by
    // "in run mode" / "armed since last release" flags.
    logic m_s1, m_s2, m_r1, m_r2;
    logic m_stable, m_en, m_run, m_armed;
    int   m_cnt;
    logic m_hist[$];
    bit   m_valid = 0;

    task automatic mdl_edge(input logic s_raw, input logic r_raw, input logic rs);
        bit all_diff;
        if (rs) begin
            m_s1 = 0; m_s2 = 0; m_r1 = 0; m_r2 = 0;
            m_stable = 0; m_en = 0; m_run = 0; m_armed = 1;
            m_cnt = 0;
            m_hist.delete();
            m_valid = 1;
            return;
        end
        if (m_en) m_cnt++;
        if (m_r2) begin
            m_run = 1; m_en = 1;
        end else if (m_run) begin
            m_run = 0; m_armed = !m_stable; m_en = 0;
        end else if (m_armed && m_stable) begin
            m_armed = 0; m_en = 1;
        end else begin
            m_en = 0;
            if (!m_stable) m_armed = 1;
        end
        m_hist.push_back(m_s2);
        if (m_hist.size() > DB) void'(m_hist.pop_front());
        all_diff = (m_hist.size() == DB);
        foreach (m_hist[k]) if (m_hist[k] == m_stable) all_diff = 0;
        if (all_diff) m_stable = !m_stable;
        m_r2 = m_r1; m_r1 = r_raw;
        m_s2 = m_s1; m_s1 = !s_raw;
    endtask

    task automatic tick(input logic s, input logic r, input logic rs);
        bus16.step = s; bus16.run = r;
        bus4.step  = s; bus4.run  = r;
        rst = rs;
        @(posedge clk);
        mdl_edge(s, r, rs);
        #1;
        if (m_valid) begin
            chk("cpu_en",     32'(bus16.cpu_en),      32'(m_en));
            chk("cpu_en_w4",  32'(bus4.cpu_en),       32'(m_en));
            chk("step_db",    32'(bus16.step_db),     32'(m_stable));
            chk("count16",    32'(bus16.cycle_count), 32'(m_cnt & 32'hFFFF));
            chk("count4",     32'(bus4.cycle_count),  32'(m_cnt & 32'hF));
        end
    endtask

    task automatic do_reset();
        tick(1'b1, 1'b0, 1'b1);
        tick(1'b1, 1'b0, 1'b1);
    endtask

    initial begin
        int en_cycles;
        int width;
        int maxw;
        int left;
        logic s;
        logic r;
        logic rs;
        bus16.step = 1'b1; bus16.run = 1'b0;
        bus4.step  = 1'b1; bus4.run  = 1'b0;

        do_reset();
        chk("rst_en",  32'(bus16.cpu_en),      32'd0);
        chk("rst_db",  32'(bus16.step_db),     32'd0);
        chk("rst_cnt", 32'(bus16.cycle_count), 32'd0);
        for (int i = 0; i < 100; i++) tick(1'b1, 1'b0, 1'b0);
        chk("idle_cnt", 32'(bus16.cycle_count), 32'd0);

        // Clean press held 50 cycles.
        for (int i = 1; i <= 50; i++) begin
            tick(1'b0, 1'b0, 1'b0);
            chk("press_db", 32'(bus16.step_db), 32'(i >= 6));
            chk("press_en", 32'(bus16.cpu_en),  32'(i == 7));
        end
        chk("press_cnt", 32'(bus16.cycle_count), 32'd1);
        for (int i = 0; i < 20; i++) tick(1'b1, 1'b0, 1'b0);
        chk("release_cnt", 32'(bus16.cycle_count), 32'd1);

        // Bounce shorter than the window, then ten clean presses.
        do_reset();
        for (int i = 0; i < 20; i++) tick(((i % 3) == 2) ? 1'b1 : 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) tick(1'b1, 1'b0, 1'b0);
        chk("bounce_cnt", 32'(bus16.cycle_count), 32'd0);
        en_cycles = 0; width = 0; maxw = 0;
        for (int p = 0; p < 10; p++) begin
            for (int i = 0; i < 20; i++) begin
                tick((i < 10) ? 1'b0 : 1'b1, 1'b0, 1'b0);
                if (bus16.cpu_en) begin
                    en_cycles++; width++;
                    if (width > maxw) maxw = width;
                end else begin
                    width = 0;
                end
            end
        end
        chk("presses_cnt",  32'(bus16.cycle_count), 32'd10);
        chk("presses_en",   32'(en_cycles),         32'd10);
        chk("pulse_width",  32'(maxw),              32'd1);

        // Free-run for 1000 cycles.
        do_reset();
        for (int i = 0; i < 1000; i++) tick(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 20; i++)   tick(1'b1, 1'b0, 1'b0);
        chk("run_cnt16", 32'(bus16.cycle_count), 32'd1000);
        chk("run_cnt4",  32'(bus4.cycle_count),  32'd8);

        // Button held across the run->step transition.
        do_reset();
        for (int i = 0; i < 1000; i++) tick(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 20; i++)   tick(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++)   tick(1'b1, 1'b0, 1'b0);
        chk("run_held_cnt", 32'(bus16.cycle_count), 32'd1000);

        // Counter wrap on the 4-bit instance.
        do_reset();
        for (int i = 0; i < 17; i++) tick(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 10; i++) tick(1'b1, 1'b0, 1'b0);
        chk("wrap_cnt4",  32'(bus4.cycle_count),  32'd1);
        chk("wrap_cnt16", 32'(bus16.cycle_count), 32'd17);

        // run_s and stable rise together: run wins, no step fires afterwards.
        do_reset();
        for (int i = 0; i < 4; i++)  tick(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) tick(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 10; i++) tick(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) tick(1'b1, 1'b0, 1'b0);
        chk("simul_cnt", 32'(bus16.cycle_count), 32'd10);

        // Reset inside the debounce window.
        do_reset();
        for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, 1'b0);
        tick(1'b1, 1'b0, 1'b1);
        chk("rst_db_en",  32'(bus16.cpu_en),      32'd0);
        chk("rst_db_db",  32'(bus16.step_db),     32'd0);
        chk("rst_db_cnt", 32'(bus16.cycle_count), 32'd0);
        for (int i = 0; i < 20; i++) tick(1'b1, 1'b0, 1'b0);
        chk("rst_db_after", 32'(bus16.cycle_count), 32'd0);

        // Reset while free-running.
        do_reset();
        for (int i = 0; i < 10; i++) tick(1'b1, 1'b1, 1'b0);
        tick(1'b1, 1'b0, 1'b1);
        chk("rst_run_en",  32'(bus16.cpu_en),      32'd0);
        chk("rst_run_cnt", 32'(bus16.cycle_count), 32'd0);
        for (int i = 0; i < 10; i++) tick(1'b1, 1'b0, 1'b0);
        chk("rst_run_after", 32'(bus16.cycle_count), 32'd0);

        // Random button runs, occasional mode flips and rare resets.
        s = 1'b1; r = 1'b0; left = 0;
        for (int i = 0; i < 4000; i++) begin
            if (left == 0) begin
                s = 1'($urandom_range(0, 1));
                left = int'($urandom_range(1, 9));
                if ($urandom_range(0, 40) == 0) r = ~r;
            end
            left--;
            rs = ($urandom_range(0, 599) == 0);
            tick(s, r, rs);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
